radix2_inverse_butterfly: RTL and testbench

Pipelined inverse of the radix-2 butterfly. It takes a sum/difference pair (s = a+b, d = a-b) for complex samples and recovers a = (s+d)/2 and b = (s-d)/2 at one bit narrower width. Used on the IFFT/reconstruction path and as a self-check partner for the forward butterfly. It has a valid/ready stream interface, range/exactness flags, and a saturating exactness-error counter.

---
 rtl/radix2_inverse_butterfly_if.sv | 36 +++
 rtl/radix2_inverse_butterfly.sv | 123 ++++++++++++
 tb/tb_radix2_inverse_butterfly.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/radix2_inverse_butterfly_if.sv
// Stream bundle for the radix-2 inverse butterfly: s/d pair in, a/b pair out,
// plus status flags and the exactness-error counter.
interface radix2_inverse_butterfly_if #(
    parameter int DATA_WIDTH_OUT = 10,
    parameter int DATA_WIDTH_IN  = DATA_WIDTH_OUT + 1,
    parameter int CNT_WIDTH      = 16
);
    logic                             in_valid;
    logic                             in_ready;
    logic signed [DATA_WIDTH_IN-1:0]  sin_real;
    logic signed [DATA_WIDTH_IN-1:0]  sin_imag;
    logic signed [DATA_WIDTH_IN-1:0]  din_real;
    logic signed [DATA_WIDTH_IN-1:0]  din_imag;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [DATA_WIDTH_OUT-1:0] aout_real;
    logic signed [DATA_WIDTH_OUT-1:0] aout_imag;
    logic signed [DATA_WIDTH_OUT-1:0] bout_real;
    logic signed [DATA_WIDTH_OUT-1:0] bout_imag;
    logic                             sat_flag;
    logic                             inexact_flag;
    logic [CNT_WIDTH-1:0]             err_count;
    logic                             cnt_clr;

    modport master (
        output in_valid, sin_real, sin_imag, din_real, din_imag, out_ready, cnt_clr,
        input  in_ready, out_valid, aout_real, aout_imag, bout_real, bout_imag,
               sat_flag, inexact_flag, err_count
    );

    modport slave (
        input  in_valid, sin_real, sin_imag, din_real, din_imag, out_ready, cnt_clr,
        output in_ready, out_valid, aout_real, aout_imag, bout_real, bout_imag,
               sat_flag, inexact_flag, err_count
    );
endinterface

// File: rtl/radix2_inverse_butterfly.sv
// Pipelined radix-2 inverse butterfly: a = (s+d)/2, b = (s-d)/2 per real/imag lane,
// saturated to DATA_WIDTH_OUT, with parity-based exactness flag and error counter.
module radix2_inverse_butterfly_lane #(
    parameter int DIN  = 11,
    parameter int DOUT = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DIN-1:0]  s,
    input  logic [DIN-1:0]  d,
    output logic [DOUT-1:0] a,
    output logic [DOUT-1:0] b,
    output logic            sat,
    output logic            odd
);
    logic [DIN:0]  sum_q, diff_q;
    logic          odd_q;
    logic [DOUT:0] a_c, b_c;

    // Returns {clipped, value}; overflow iff the bits above DOUT-1 are not a pure sign extension.
    function automatic logic [DOUT:0] clip(input logic [DIN-1:0] v);
        logic [DIN-DOUT:0] hi;
        hi = v[DIN-1:DOUT-1];
        if (!hi[DIN-DOUT] && (|hi))
            clip = {1'b1, 1'b0, {(DOUT-1){1'b1}}};
        else if (hi[DIN-DOUT] && !(&hi))
            clip = {1'b1, 1'b1, {(DOUT-1){1'b0}}};
        else
            clip = {1'b0, v[DOUT-1:0]};
    endfunction

    // Dropping the LSB of the widened sum/diff is the floor shift.
    assign a_c = clip(sum_q[DIN:1]);
    assign b_c = clip(diff_q[DIN:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            diff_q <= '0;
            odd_q  <= 1'b0;
            a      <= '0;
            b      <= '0;
            sat    <= 1'b0;
            odd    <= 1'b0;
        end else if (en) begin
            sum_q  <= {s[DIN-1], s} + {d[DIN-1], d};
            diff_q <= {s[DIN-1], s} - {d[DIN-1], d};
            odd_q  <= s[0] ^ d[0];
            a      <= a_c[DOUT-1:0];
            b      <= b_c[DOUT-1:0];
            sat    <= a_c[DOUT] | b_c[DOUT];
            odd    <= odd_q;
        end
    end
endmodule

module radix2_inverse_butterfly #(
    parameter int DATA_WIDTH_OUT = 10,
    parameter int DATA_WIDTH_IN  = DATA_WIDTH_OUT + 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    radix2_inverse_butterfly_if.slave     bus
);
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 2;

    logic [NUM_LANES-1:0][DATA_WIDTH_IN-1:0]  s_l, d_l;
    logic [NUM_LANES-1:0][DATA_WIDTH_OUT-1:0] a_l, b_l;
    logic [NUM_LANES-1:0]                     sat_l, odd_l;
    logic [STAGES:1]                          vld_pipe;
    logic [CNT_WIDTH-1:0]                     cnt;
    logic                                     en, in_hs, out_hs;

    // Whole pipe advances together; a stalled output freezes both stages.
    assign en     = !vld_pipe[STAGES] || bus.out_ready;
    assign in_hs  = bus.in_valid && en;
    assign out_hs = vld_pipe[STAGES] && bus.out_ready;

    assign s_l = {bus.sin_imag, bus.sin_real};
    assign d_l = {bus.din_imag, bus.din_real};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        radix2_inverse_butterfly_lane #(
            .DIN  (DATA_WIDTH_IN),
            .DOUT (DATA_WIDTH_OUT)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .s   (s_l[i]),
            .d   (d_l[i]),
            .a   (a_l[i]),
            .b   (b_l[i]),
            .sat (sat_l[i]),
            .odd (odd_l[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_hs};
    end

    // Clear has priority; counter sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       cnt <= '0;
        else if (bus.cnt_clr)                          cnt <= '0;
        else if (out_hs && (|odd_l) && !(&cnt))        cnt <= cnt + 1'b1;
    end

    assign bus.in_ready     = en;
    assign bus.out_valid    = vld_pipe[STAGES];
    assign bus.aout_real    = a_l[0];
    assign bus.aout_imag    = a_l[1];
    assign bus.bout_real    = b_l[0];
    assign bus.bout_imag    = b_l[1];
    assign bus.sat_flag     = |sat_l;
    assign bus.inexact_flag = |odd_l;
    assign bus.err_count    = cnt;
endmodule

// File: tb/tb_radix2_inverse_butterfly.sv
// Directed-vector bench for radix2_inverse_butterfly (DATA_WIDTH_OUT=10, CNT_WIDTH=4).
module tb_radix2_inverse_butterfly;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    radix2_inverse_butterfly_if #(.DATA_WIDTH_OUT(10), .CNT_WIDTH(4)) bus ();
    radix2_inverse_butterfly #(.DATA_WIDTH_OUT(10), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int sr, input int si, input int dr, input int di);
        bus.sin_real = 11'(sr);
        bus.sin_imag = 11'(si);
        bus.din_real = 11'(dr);
        bus.din_imag = 11'(di);
    endtask

    function automatic logic [39:0] pk(input int ar, input int ai, input int br, input int bi);
        return {10'(ar), 10'(ai), 10'(br), 10'(bi)};
    endfunction

    function automatic logic [39:0] outs();
        return {bus.aout_real, bus.aout_imag, bus.bout_real, bus.bout_imag};
    endfunction

    task automatic test_reset;
        #3;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (outs() !== 40'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", outs()); end
        n_cmp++; if ({bus.sat_flag, bus.inexact_flag} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {bus.sat_flag, bus.inexact_flag}); end
        n_cmp++; if (bus.err_count !== 4'd0) begin n_bad++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        step;
        rst = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_exact;
        set_pair(-100, -25, 300, -75);
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL exact_early_valid got %b want 0", bus.out_valid); end
        step;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL exact_latency got %b want 1", bus.out_valid); end
        n_cmp++; if (outs() !== pk(100, -50, -200, 25)) begin n_bad++; $display("FAIL exact_data got %h want %h", outs(), pk(100, -50, -200, 25)); end
        n_cmp++; if ({bus.sat_flag, bus.inexact_flag} !== 2'b00) begin n_bad++; $display("FAIL exact_flags got %b want 00", {bus.sat_flag, bus.inexact_flag}); end
        step;
    endtask

    task automatic test_extremes;
        set_pair(-1024, 1022, 0, 0);
        bus.in_valid = 1'b1;
        step;
        set_pair(1023, 0, 1023, 0);
        step;
        bus.in_valid = 1'b0;
        n_cmp++; if (outs() !== pk(-512, 511, -512, 511)) begin n_bad++; $display("FAIL extreme_data got %h want %h", outs(), pk(-512, 511, -512, 511)); end
        n_cmp++; if ({bus.out_valid, bus.sat_flag, bus.inexact_flag} !== 3'b100) begin n_bad++; $display("FAIL extreme_flags got %b want 100", {bus.out_valid, bus.sat_flag, bus.inexact_flag}); end
        step;
        n_cmp++; if (outs() !== pk(511, 0, 0, 0)) begin n_bad++; $display("FAIL clip_data got %h want %h", outs(), pk(511, 0, 0, 0)); end
        n_cmp++; if ({bus.out_valid, bus.sat_flag, bus.inexact_flag} !== 3'b110) begin n_bad++; $display("FAIL clip_flags got %b want 110", {bus.out_valid, bus.sat_flag, bus.inexact_flag}); end
        step;
    endtask

    task automatic test_inexact_counter;
        bus.cnt_clr = 1'b1;
        step;
        bus.cnt_clr = 1'b0;
        set_pair(3, 0, 0, 0);
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        step;
        n_cmp++; if (outs() !== pk(1, 0, 1, 0)) begin n_bad++; $display("FAIL inexact_data got %h want %h", outs(), pk(1, 0, 1, 0)); end
        n_cmp++; if ({bus.out_valid, bus.inexact_flag, bus.err_count} !== {2'b11, 4'd0}) begin n_bad++; $display("FAIL inexact_pre got %b want 110000", {bus.out_valid, bus.inexact_flag, bus.err_count}); end
        step;
        n_cmp++; if (bus.err_count !== 4'd1) begin n_bad++; $display("FAIL cnt_first got %0d want 1", bus.err_count); end
        bus.in_valid = 1'b1;
        repeat (20) step;
        bus.in_valid = 1'b0;
        repeat (3) step;
        n_cmp++; if (bus.err_count !== 4'd15) begin n_bad++; $display("FAIL cnt_saturate got %0d want 15", bus.err_count); end
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        step;
        n_cmp++; if ({bus.out_valid, bus.inexact_flag} !== 2'b11) begin n_bad++; $display("FAIL clr_setup got %b want 11", {bus.out_valid, bus.inexact_flag}); end
        bus.cnt_clr = 1'b1;
        step;
        bus.cnt_clr = 1'b0;
        n_cmp++; if (bus.err_count !== 4'd0) begin n_bad++; $display("FAIL cnt_clr_wins got %0d want 0", bus.err_count); end
    endtask

    task automatic test_backpressure;
        int ar[8], ai[8], br[8], bi[8];
        int sent = 0;
        int rcv = 0;
        logic [39:0] snap = '0;
        for (int i = 0; i < 8; i++) begin
            ar[i] = i * 30 - 100; br[i] = 50 - i * 7; ai[i] = i; bi[i] = -2 * i;
        end
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            bus.in_valid = (sent < 8);
            if (sent < 8) set_pair(ar[sent] + br[sent], ai[sent] + bi[sent], ar[sent] - br[sent], ai[sent] - bi[sent]);
            bus.out_ready = !(c >= 4 && c <= 6);
            #1;
            if (c >= 4 && c <= 6) begin
                n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, bus.in_ready); end
            end
            if (c == 4) snap = outs();
            if (c == 5 || c == 6) begin
                n_cmp++; if (outs() !== snap || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold c=%0d got %h want %h", c, outs(), snap); end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++; if (outs() !== pk(ar[rcv], ai[rcv], br[rcv], bi[rcv])) begin n_bad++; $display("FAIL bp_order idx=%0d got %h want %h", rcv, outs(), pk(ar[rcv], ai[rcv], br[rcv], bi[rcv])); end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            step;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (rcv != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", rcv); end
        step;
        step;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dup got %b want 0", bus.out_valid); end
    endtask

    task automatic test_bubbles;
        logic iv[12];
        logic want;
        set_pair(0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            iv[c] = (c < 8) && (c % 2 == 0);
            bus.in_valid = iv[c];
            want = (c >= 2) ? iv[c - 2] : 1'b0;
            n_cmp++; if (bus.out_valid !== want) begin n_bad++; $display("FAIL bubble c=%0d got %b want %b", c, bus.out_valid, want); end
            step;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        int stray = 0;
        set_pair(3, 0, 0, 0);
        bus.in_valid = 1'b1;
        repeat (3) step;
        bus.in_valid = 1'b0;
        n_cmp++; if ({bus.out_valid, bus.err_count} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL mid_pre got %b want 10001", {bus.out_valid, bus.err_count}); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.out_valid, bus.err_count} !== 5'b0) begin n_bad++; $display("FAIL mid_async got %b want 00000", {bus.out_valid, bus.err_count}); end
        n_cmp++; if ({outs(), bus.inexact_flag} !== 41'h0) begin n_bad++; $display("FAIL mid_data got %h want 0", {outs(), bus.inexact_flag}); end
        step;
        rst = 1'b0;
        repeat (4) begin
            if (bus.out_valid !== 1'b0) stray++;
            step;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL mid_stale got %0d want 0", stray); end
        set_pair(-100, -25, 300, -75);
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        step;
        n_cmp++; if (bus.out_valid !== 1'b1 || outs() !== pk(100, -50, -200, 25)) begin n_bad++; $display("FAIL mid_after got %b/%h want 1/%h", bus.out_valid, outs(), pk(100, -50, -200, 25)); end
        step;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.cnt_clr = 1'b0;
        set_pair(0, 0, 0, 0);
        test_reset;
        test_exact;
        test_extremes;
        test_inexact_counter;
        test_backpressure;
        test_bubbles;
        test_reset_midstream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
